// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for mem_write_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOADER_BUSY = 2'd1,
        CORE_BUSY   = 2'd2
    } arb_state_t;

    typedef enum logic {
        LOADER = 1'b0,
        CORE   = 1'b1
    } grant_t;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_write_arbiter_loader_fifo.sv
// rtl/mem_write_arbiter_loader_fifo.sv - show-ahead FIFO absorbing loader write pulses
module loader_fifo
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the sticky dropped-write flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - serializes loader writes and core requests onto one memory port
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_SIZE = 28,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_memory,
    input  logic                    reset,
    input  logic                    loader_write_en,
    input  logic [ADDRESS_SIZE-1:0] loader_write_addr,
    input  logic [DATA_WIDTH-1:0]   loader_write_data,
    input  logic                    core_req,
    input  logic                    core_we,
    input  logic [ADDRESS_SIZE-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    output logic                    core_ack,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    overflow
);

    localparam int WORD_W = ADDRESS_SIZE + DATA_WIDTH;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_data_width
        $error("mem_write_arbiter: DATA_WIDTH must be 8 or 16");
    end

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("mem_write_arbiter: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [WORD_W-1:0]       fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;

    arb_state_t              state;
    arb_state_t              state_next;
    grant_t                  last_grant;
    grant_t                  last_grant_next;
    logic                    mem_req_next;
    logic                    mem_we_next;
    logic [ADDRESS_SIZE-1:0] mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_next;
    logic                    core_ack_next;
    logic [DATA_WIDTH-1:0]   core_rdata_next;

    loader_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_loader_fifo (
        .clk       (clk_memory),
        .reset     (reset),
        .push      (loader_write_en),
        .push_data ({loader_write_addr, loader_write_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign busy = !fifo_empty || (state != IDLE);

    // State, fairness memory and every registered output toward memory and core.
    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CORE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= 1'b0;
            core_rdata <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            mem_req    <= mem_req_next;
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            core_ack   <= core_ack_next;
            core_rdata <= core_rdata_next;
        end
    end

    // Arbitration in IDLE and handshake completion in the busy states.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_req_next    = mem_req;
        mem_we_next     = mem_we;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        core_ack_next   = 1'b0;
        core_rdata_next = core_rdata;
        fifo_pop        = 1'b0;

        case (state)
            IDLE: begin
                // Loader wins when the FIFO is full, when it is alone, or when it is its turn.
                if (!fifo_empty && (fifo_full || !core_req || last_grant == CORE)) begin
                    state_next      = LOADER_BUSY;
                    last_grant_next = LOADER;
                    mem_req_next    = 1'b1;
                    mem_we_next     = 1'b1;
                    mem_addr_next   = fifo_head[WORD_W-1 -: ADDRESS_SIZE];
                    mem_wdata_next  = fifo_head[DATA_WIDTH-1:0];
                end else if (core_req) begin
                    state_next      = CORE_BUSY;
                    last_grant_next = CORE;
                    mem_req_next    = 1'b1;
                    mem_we_next     = core_we;
                    mem_addr_next   = core_addr;
                    mem_wdata_next  = core_wdata;
                end
            end
            LOADER_BUSY: begin
                if (mem_ack) begin
                    fifo_pop     = 1'b1;
                    mem_req_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            CORE_BUSY: begin
                if (mem_ack) begin
                    core_ack_next   = 1'b1;
                    core_rdata_next = mem_rdata;
                    mem_req_next    = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - self-checking bench for mem_write_arbiter
module tb_mem_write_arbiter;

    localparam int AW    = 28;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NVEC  = 6;

    logic          clk_memory = 1'b0;
    logic          reset;
    logic          loader_write_en;
    logic [AW-1:0] loader_write_addr;
    logic [DW-1:0] loader_write_data;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          overflow;

    always #5 clk_memory = ~clk_memory;

    mem_write_arbiter #(
        .ADDRESS_SIZE (AW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_memory        (clk_memory),
        .reset             (reset),
        .loader_write_en   (loader_write_en),
        .loader_write_addr (loader_write_addr),
        .loader_write_data (loader_write_data),
        .core_req          (core_req),
        .core_we           (core_we),
        .core_addr         (core_addr),
        .core_wdata        (core_wdata),
        .core_ack          (core_ack),
        .core_rdata        (core_rdata),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .busy              (busy),
        .overflow          (overflow)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        string         name;
        bit            is_core;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            delay;
        int            exp_lat;
        logic          exp_we;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    int   checks = 0;
    int   errors = 0;

    bit   resp_en    = 1'b0;
    bit   rand_delay = 1'b0;
    int   ack_delay  = 2;
    int   cur_delay;
    int   wait_cnt;
    bit   in_txn;
    txn_t txn_log[$];
    txn_t cur_core;

    bit                 model_on = 1'b0;
    bit                 exp_ovf;
    logic [AW+DW-1:0]   model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 8'h3C;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_memory);
            #1;
        end
    endtask

    task automatic loader_pulse(input logic [AW-1:0] a, input logic [DW-1:0] d);
        loader_write_en   = 1'b1;
        loader_write_addr = a;
        loader_write_data = d;
        tick();
        loader_write_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || mem_req) && n < budget) begin
            tick();
            n++;
        end
        check({name, " busy cleared"}, busy, 0);
    endtask

    task automatic core_access(input string name, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        int n;
        core_we    = we;
        core_addr  = a;
        core_wdata = d;
        cur_core   = '{we, a, d};
        core_req   = 1'b1;
        n = 0;
        while (!core_ack && n < 1000) begin
            tick();
            n++;
        end
        check({name, " core_ack"}, core_ack, 1);
        check({name, " core_rdata"}, core_rdata, rdata_of(a));
        core_req = 1'b0;
        tick();
        check({name, " core_ack single pulse"}, core_ack, 0);
    endtask

    task automatic reset_dut();
        reset           = 1'b1;
        resp_en         = 1'b0;
        rand_delay      = 1'b0;
        mem_ack         = 1'b0;
        loader_write_en = 1'b0;
        core_req        = 1'b0;
        tick(2);
        reset = 1'b0;
        tick();
        txn_log.delete();
    endtask

    // Memory controller: acks each request after a chosen delay and logs what it saw.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        in_txn    = 1'b0;
        cur_delay = 0;
        forever begin
            @(posedge clk_memory);
            #1;
            if (reset) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                in_txn   = 1'b0;
            end else if (resp_en && mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                in_txn   = 1'b0;
            end else if (resp_en && mem_req) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_cnt  = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 4)) : ack_delay;
                end
                if (wait_cnt >= cur_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_of(mem_addr);
                    txn_log.push_back('{mem_we, mem_addr, mem_wdata});
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Reference model: loader writes as an ordered bounded queue, popped when the controller acks one.
    always @(negedge clk_memory) begin
        bit lpop;
        int sz;
        if (model_on && !reset) begin
            sz   = model_q.size();
            lpop = mem_ack && mem_req && !mem_addr[AW-1];
            check("rnd overflow", overflow, exp_ovf);
            if (mem_ack && mem_req && mem_addr[AW-1]) begin
                check("rnd core mem_we", mem_we, cur_core.we);
                check("rnd core mem_addr", mem_addr, cur_core.addr);
                check("rnd core mem_wdata", mem_wdata, cur_core.wdata);
            end
            if (lpop) begin
                check("rnd loader queue nonempty", sz > 0, 1);
                if (sz > 0) begin
                    check("rnd loader order", {mem_addr, mem_wdata}, model_q[0]);
                    void'(model_q.pop_front());
                end
            end
            if (loader_write_en) begin
                if (sz == DEPTH && !lpop) begin
                    exp_ovf = 1'b1;
                end else begin
                    model_q.push_back({loader_write_addr, loader_write_data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[NVEC];
        vec_t          v;
        int            lat;
        int            n;
        logic [AW-1:0] alt_exp[6];

        vecs[0] = '{"ldr_a5",   1'b0, 1'b1, 28'h0000100, 8'hA5, 2, 2, 1'b1, 8'h00};
        vecs[1] = '{"core_rd",  1'b1, 1'b0, 28'h0000200, 8'h00, 2, 1, 1'b0, 8'h3C};
        vecs[2] = '{"core_wr",  1'b1, 1'b1, 28'h8000123, 8'h77, 0, 1, 1'b1, 8'h1F};
        vecs[3] = '{"ldr_max",  1'b0, 1'b1, 28'hFFFFFFF, 8'hFF, 0, 2, 1'b1, 8'h00};
        vecs[4] = '{"core_slow",1'b1, 1'b0, 28'h0ABCDEF, 8'h5A, 5, 1, 1'b0, 8'hD3};
        vecs[5] = '{"ldr_zero", 1'b0, 1'b1, 28'h0000000, 8'h00, 1, 2, 1'b1, 8'h00};

        reset             = 1'b1;
        loader_write_en   = 1'b0;
        loader_write_addr = '0;
        loader_write_data = '0;
        core_req          = 1'b0;
        core_we           = 1'b0;
        core_addr         = '0;
        core_wdata        = '0;
        #12;
        check("reset core_ack", core_ack, 0);
        check("reset core_rdata", core_rdata, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        reset_dut();

        // Single transactions from an idle block.
        for (int i = 0; i < NVEC; i++) begin
            v         = vecs[i];
            ack_delay = v.delay;
            resp_en   = 1'b1;
            if (v.is_core) begin
                core_we    = v.we;
                core_addr  = v.addr;
                core_wdata = v.data;
                core_req   = 1'b1;
            end else begin
                loader_write_en   = 1'b1;
                loader_write_addr = v.addr;
                loader_write_data = v.data;
            end
            tick();
            loader_write_en = 1'b0;
            lat = 1;
            while (!mem_req && lat < 10) begin
                tick();
                lat++;
            end
            check({v.name, " req latency"}, lat, v.exp_lat);
            check({v.name, " mem_we"}, mem_we, v.exp_we);
            check({v.name, " mem_addr"}, mem_addr, v.addr);
            check({v.name, " mem_wdata"}, mem_wdata, v.data);
            if (v.is_core) begin
                n = 0;
                while (!core_ack && n < 20) begin
                    tick();
                    n++;
                end
                check({v.name, " core_ack"}, core_ack, 1);
                check({v.name, " core_rdata"}, core_rdata, v.exp_rdata);
                core_req = 1'b0;
                tick();
                check({v.name, " core_ack single pulse"}, core_ack, 0);
            end
            wait_idle(v.name, 20);
        end

        // Both requesters pending: grants alternate, loader first after reset.
        reset_dut();
        resp_en   = 1'b1;
        ack_delay = 1;
        alt_exp   = '{28'h0000011, 28'h8000021, 28'h0000012, 28'h8000022, 28'h0000013, 28'h8000023};
        loader_write_en   = 1'b1;
        loader_write_addr = alt_exp[0];
        loader_write_data = 8'h11;
        tick();
        fork
            begin
                loader_write_addr = alt_exp[2];
                loader_write_data = 8'h12;
                tick();
                loader_write_addr = alt_exp[4];
                loader_write_data = 8'h13;
                tick();
                loader_write_en = 1'b0;
            end
            begin
                core_access("alt c0", 1'b0, alt_exp[1], 8'h00);
                core_access("alt c1", 1'b1, alt_exp[3], 8'h66);
                core_access("alt c2", 1'b0, alt_exp[5], 8'h00);
            end
        join
        n = 0;
        while ((txn_log.size() < 6 || busy) && n < 100) begin
            tick();
            n++;
        end
        check("alt txn count", txn_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < txn_log.size()) begin
                check($sformatf("alt grant %0d addr", k), txn_log[k].addr, alt_exp[k]);
            end
        end

        // Stalled controller, five loader pulses into a depth-4 FIFO.
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            loader_pulse(28'h0000300 + 28'(k), 8'h40 + 8'(k));
            tick();
        end
        check("ovf set", overflow, 1);
        tick(20);
        check("ovf sticky", overflow, 1);
        check("ovf req held", mem_req, 1);
        resp_en   = 1'b1;
        ack_delay = 0;
        n = 0;
        while ((txn_log.size() < 4 || busy) && n < 100) begin
            tick();
            n++;
        end
        check("ovf drained count", txn_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < txn_log.size()) begin
                check($sformatf("ovf drain %0d", k), {txn_log[k].addr, txn_log[k].wdata},
                      {28'h0000300 + 28'(k), 8'h40 + 8'(k)});
            end
        end
        check("ovf after drain", overflow, 1);

        // Full FIFO: push and pop in the same cycle, then the wrapped order.
        reset_dut();
        loader_write_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            loader_write_addr = 28'h0000400 + 28'(k);
            loader_write_data = 8'hB0 + 8'(k);
            tick();
        end
        loader_write_en = 1'b0;
        tick(3);
        check("wrap head req", mem_req, 1);
        check("wrap head addr", mem_addr, 28'h0000400);
        mem_ack           = 1'b1;
        loader_write_en   = 1'b1;
        loader_write_addr = 28'h0000404;
        loader_write_data = 8'hB4;
        tick();
        mem_ack         = 1'b0;
        loader_write_en = 1'b0;
        check("wrap no overflow", overflow, 0);
        tick();
        loader_pulse(28'h0000405, 8'hB5);
        tick();
        check("wrap still full", overflow, 1);
        resp_en   = 1'b1;
        ack_delay = 1;
        n = 0;
        while ((txn_log.size() < 4 || busy) && n < 100) begin
            tick();
            n++;
        end
        check("wrap drained count", txn_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < txn_log.size()) begin
                check($sformatf("wrap drain %0d", k), {txn_log[k].addr, txn_log[k].wdata},
                      {28'h0000401 + 28'(k), 8'hB1 + 8'(k)});
            end
        end

        // Asynchronous reset in the middle of a core transaction.
        reset_dut();
        core_we   = 1'b0;
        core_addr = 28'h8000500;
        core_req  = 1'b1;
        tick(2);
        check("rst core in flight", mem_req, 1);
        for (int k = 0; k < 5; k++) begin
            loader_pulse(28'h0000600 + 28'(k), 8'hC0 + 8'(k));
        end
        tick();
        check("rst ovf before", overflow, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst mem_req immediate", mem_req, 0);
        check("rst core_ack immediate", core_ack, 0);
        check("rst busy immediate", busy, 0);
        core_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rst released mem_req", mem_req, 0);
        check("rst released busy", busy, 0);
        check("rst released overflow", overflow, 0);

        // Randomized traffic against the queue model.
        reset_dut();
        model_q.delete();
        exp_ovf    = 1'b0;
        rand_delay = 1'b1;
        resp_en    = 1'b1;
        model_on   = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    loader_pulse({1'b0, 27'($urandom)}, 8'($urandom));
                    tick(int'($urandom_range(0, 6)));
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    core_access($sformatf("rnd core %0d", k), 1'($urandom),
                                {1'b1, 27'($urandom)}, 8'($urandom));
                    tick(int'($urandom_range(0, 8)));
                end
            end
        join
        wait_idle("rnd", 200);
        tick();
        model_on = 1'b0;
        check("rnd model drained", model_q.size(), 0);
        check("rnd final overflow", overflow, exp_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
